// File: rtl/axil_master.sv
// axil_master
// AXI4-Lite initiator. Takes single-word read/write commands from a local
// command port, runs one AXI-Lite transaction at a time, and returns the
// read data and response on a response port. A per-phase watchdog aborts
// any transaction whose responder stops answering.
//
// Ports:
//   aclk, aresetn              clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_ready is high only in IDLE
//   cmd_we, cmd_addr, cmd_wdata  command: 1 = write, address, write data
//   rsp_valid/rsp_ready        response handshake
//   rsp_we, rsp_rdata          echoed direction, read data (0 for writes)
//   rsp_resp, rsp_timeout      bus response (2'b10 on abort), abort flag
//   aw*/w*/b*/ar*/r*           manager side of the AXI-Lite channels
module axil_master #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_we,
  input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0] cmd_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_we,
  output logic [AXI_DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      rsp_timeout,
  output logic [AXI_ADDR_WIDTH-1:0] awaddr,
  output logic                      awvalid,
  input  logic                      awready,
  output logic [AXI_DATA_WIDTH-1:0] wdata,
  output logic                      wvalid,
  input  logic                      wready,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready,
  output logic [AXI_ADDR_WIDTH-1:0] araddr,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [AXI_DATA_WIDTH-1:0] rdata,
  input  logic [1:0]                rresp,
  input  logic                      rvalid,
  output logic                      rready
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

  // The abort fires on the edge where the count would reach TIMEOUT_CYCLES,
  // so a stuck valid is held for exactly TIMEOUT_CYCLES cycles.
  localparam bit                   TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 accept, in_wait, timeout_hit, abort;

  logic                      cmd_ready_d, rsp_valid_d, rsp_we_d, rsp_timeout_d;
  logic [AXI_DATA_WIDTH-1:0] rsp_rdata_d, wdata_d;
  logic [1:0]                rsp_resp_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_d, araddr_d;
  logic                      awvalid_d, wvalid_d, arvalid_d, bready_d, rready_d;

  assign accept      = (state == IDLE) && cmd_valid && cmd_ready;
  assign in_wait     = (state == WR_REQ) || (state == WR_RESP) ||
                       (state == RD_REQ) || (state == RD_DATA);
  assign timeout_hit = TO_EN && in_wait && (cnt == TO_LAST);

  // State register plus every registered output; the counter restarts on
  // any state change and only runs while waiting on the bus.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      cnt         <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_we      <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= 2'b00;
      rsp_timeout <= 1'b0;
      awaddr      <= '0;
      awvalid     <= 1'b0;
      wdata       <= '0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
      araddr      <= '0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= (state_nxt != state) ? '0 : (in_wait ? cnt + CNT_WIDTH'(1) : cnt);
      cmd_ready   <= cmd_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_we      <= rsp_we_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_resp    <= rsp_resp_d;
      rsp_timeout <= rsp_timeout_d;
      awaddr      <= awaddr_d;
      awvalid     <= awvalid_d;
      wdata       <= wdata_d;
      wvalid      <= wvalid_d;
      bready      <= bready_d;
      araddr      <= araddr_d;
      arvalid     <= arvalid_d;
      rready      <= rready_d;
    end
  end

  // Next-state logic. A handshake landing on the timeout edge still
  // completes normally; abort only when the phase is genuinely stuck.
  always_comb begin
    state_nxt = state;
    abort     = 1'b0;
    case (state)
      IDLE:    if (accept) state_nxt = cmd_we ? WR_REQ : RD_REQ;
      WR_REQ: begin
        // AW and W finish independently; a channel is done once its valid is low
        // or its handshake is happening this cycle.
        if ((!awvalid || awready) && (!wvalid || wready)) state_nxt = WR_RESP;
        else if (timeout_hit) begin state_nxt = RSP; abort = 1'b1; end
      end
      WR_RESP: begin
        if (bvalid && bready)  state_nxt = RSP;
        else if (timeout_hit) begin state_nxt = RSP; abort = 1'b1; end
      end
      RD_REQ: begin
        if (arvalid && arready) state_nxt = RD_DATA;
        else if (timeout_hit) begin state_nxt = RSP; abort = 1'b1; end
      end
      RD_DATA: begin
        if (rvalid && rready)  state_nxt = RSP;
        else if (timeout_hit) begin state_nxt = RSP; abort = 1'b1; end
      end
      RSP:     if (rsp_valid && rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the output registers. Ready/valid levels that belong to
  // a state are decoded from the next state so they switch on the same edge.
  always_comb begin
    cmd_ready_d   = (state_nxt == IDLE);
    rsp_valid_d   = (state_nxt == RSP);
    bready_d      = (state_nxt == WR_RESP);
    rready_d      = (state_nxt == RD_DATA);
    awvalid_d     = 1'b0;
    wvalid_d      = 1'b0;
    arvalid_d     = 1'b0;
    awaddr_d      = awaddr;
    araddr_d      = araddr;
    wdata_d       = wdata;
    rsp_we_d      = rsp_we;
    rsp_rdata_d   = rsp_rdata;
    rsp_resp_d    = rsp_resp;
    rsp_timeout_d = rsp_timeout;
    case (state)
      IDLE: if (accept) begin
        awvalid_d     = cmd_we;
        wvalid_d      = cmd_we;
        arvalid_d     = !cmd_we;
        if (cmd_we) begin
          awaddr_d = cmd_addr;
          wdata_d  = cmd_wdata;
        end else begin
          araddr_d = cmd_addr;
        end
        rsp_we_d      = cmd_we;
        rsp_rdata_d   = '0;
        rsp_resp_d    = 2'b00;
        rsp_timeout_d = 1'b0;
      end
      WR_REQ: begin
        awvalid_d = (state_nxt == WR_REQ) && awvalid && !awready;
        wvalid_d  = (state_nxt == WR_REQ) && wvalid && !wready;
      end
      WR_RESP: if (state_nxt == RSP && !abort) begin
        rsp_resp_d  = bresp;
        rsp_rdata_d = '0;
      end
      RD_REQ: arvalid_d = (state_nxt == RD_REQ) && arvalid && !arready;
      RD_DATA: if (state_nxt == RSP && !abort) begin
        rsp_resp_d  = rresp;
        rsp_rdata_d = rdata;
      end
      default: ;
    endcase
    if (abort) begin
      rsp_timeout_d = 1'b1;
      rsp_resp_d    = 2'b10;
      rsp_rdata_d   = '0;
    end
  end

endmodule
